// File: rtl/ysyx_23060025_burst_mem_pkg.sv
// Shared constants and helpers for the burst-read memory responder.
//   AXI_ADDR_SIZE_4   : arsize encoding of a 4-byte beat (the only legal size)
//   AXI_BURST_MAX_LEN : longest INCR burst in beats (arlen + 1 <= 256)
//   addr_fault()      : request-level protocol check raised at acceptance
package ysyx_23060025_burst_mem_pkg;

  localparam logic [2:0] AXI_ADDR_SIZE_4   = 3'b010;
  localparam int         AXI_BURST_MAX_LEN = 256;

  // A request is malformed when it is not a 4-byte beat or the start
  // address is not word aligned.
  function automatic logic addr_fault(input logic [1:0] addr_lo,
                                      input logic [2:0] arsize);
    return (arsize != AXI_ADDR_SIZE_4) || (addr_lo != 2'b00);
  endfunction

endpackage

// File: rtl/ysyx_23060025_burst_mem_array.sv
// Word array behind the burst responder.
//   clock, reset      : clock; reset clears only the read-data register
//   rd_en, rd_addr    : synchronous read request, data appears next cycle
//   rd_data           : registered read data, holds when rd_en is low
//   wr_en, wr_addr,
//   wr_data           : synchronous word write
// A read and a write to the same word in one cycle return the old word.
module ysyx_23060025_burst_mem_array #(
  parameter int DEPTH_W = 10,
  parameter int DATA_W  = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               rd_en,
  input  logic [DEPTH_W-1:0] rd_addr,
  output logic [DATA_W-1:0]  rd_data,
  input  logic               wr_en,
  input  logic [DEPTH_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]  wr_data
);

  logic [DATA_W-1:0] mem [2**DEPTH_W];

  // Contents are deliberately left out of reset so a preloaded image
  // survives a reset pulse.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ysyx_23060025_burst_mem.sv
// Burst-read memory responder for the instruction-fetch refill path.
//   clock, reset          : clock, asynchronous active-high reset
//   in_paddr, in_psel,
//   in_arlen, in_arsize   : burst request; psel is held until the last beat
//   out_rvalid, out_rlast,
//   out_rdata             : one registered beat per BEAT cycle, no back-pressure
//   out_err               : sticky malformed-request flag
//   dbg_state             : current FSM state for checkers
//   wr_en, wr_addr,
//   wr_data               : backdoor word write for program preload
// Handshake: a request is accepted on the first edge in IDLE that samples
// in_psel = 1; beats are presented with out_rvalid and are consumed on the
// same edge unconditionally; after the last beat the responder waits for
// in_psel = 0 before it can accept again.
module ysyx_23060025_burst_mem
  import ysyx_23060025_burst_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH_W = 10,
  parameter int FIRST_LAT   = 2,
  parameter int BEAT_GAP    = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [ADDR_WIDTH-1:0]  in_paddr,
  input  logic                   in_psel,
  input  logic [7:0]             in_arlen,
  input  logic [2:0]             in_arsize,
  output logic                   out_rvalid,
  output logic                   out_rlast,
  output logic [DATA_WIDTH-1:0]  out_rdata,
  output logic                   out_err,
  output logic [2:0]             dbg_state,
  input  logic                   wr_en,
  input  logic [MEM_DEPTH_W-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]  wr_data
);

  localparam int         BEAT_CNT_W = $clog2(AXI_BURST_MAX_LEN);
  localparam logic [3:0] LAT_LOAD   = 4'(FIRST_LAT - 1);
  localparam logic [3:0] GAP_LOAD   = 4'(BEAT_GAP);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_BEAT    = 3'd2,
    ST_GAP     = 3'd3,
    ST_RELEASE = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [MEM_DEPTH_W-1:0] word_idx_q;
  logic [BEAT_CNT_W-1:0]  beats_left_q;
  logic [3:0]             lat_cnt_q;
  logic [3:0]             gap_cnt_q;

  logic accept, last_beat;
  logic rd_en, rvalid_d, rlast_d, err_d;

  // Address bits above the word index only alias the array.
  logic unused_addr_hi;
  assign unused_addr_hi = ^in_paddr[ADDR_WIDTH-1:MEM_DEPTH_W+2];

  assign accept    = (state_q == ST_IDLE) && in_psel;
  assign last_beat = (beats_left_q == '0);
  assign dbg_state = state_q;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. Counters are compared against 1 because the
  // transition happens on the edge where their decrement reaches 0.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (in_psel) state_d = (FIRST_LAT == 1) ? ST_BEAT : ST_WAIT;
      ST_WAIT:    if (lat_cnt_q == 4'd1) state_d = ST_BEAT;
      ST_BEAT: begin
        if (last_beat)         state_d = ST_RELEASE;
        else if (BEAT_GAP > 0) state_d = ST_GAP;
        else                   state_d = ST_BEAT;
      end
      ST_GAP:     if (gap_cnt_q == 4'd1) state_d = ST_BEAT;
      ST_RELEASE: if (!in_psel) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered beat outputs. A cycle in
  // BEAT reads the array, so the beat is visible one cycle later.
  always_comb begin
    rd_en    = (state_q == ST_BEAT);
    rvalid_d = (state_q == ST_BEAT);
    rlast_d  = (state_q == ST_BEAT) && last_beat;
    err_d    = out_err || (accept && addr_fault(in_paddr[1:0], in_arsize));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_rvalid <= 1'b0;
      out_rlast  <= 1'b0;
      out_err    <= 1'b0;
    end else begin
      out_rvalid <= rvalid_d;
      out_rlast  <= rlast_d;
      out_err    <= err_d;
    end
  end

  // Burst bookkeeping: word pointer, remaining beats, latency and gap timers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word_idx_q   <= '0;
      beats_left_q <= '0;
      lat_cnt_q    <= '0;
      gap_cnt_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_psel) begin
            word_idx_q   <= in_paddr[MEM_DEPTH_W+1:2];
            beats_left_q <= in_arlen;
            lat_cnt_q    <= LAT_LOAD;
          end
        end
        ST_WAIT: lat_cnt_q <= lat_cnt_q - 4'd1;
        ST_BEAT: begin
          if (!last_beat) begin
            // Index wraps naturally at the array size.
            word_idx_q   <= word_idx_q + 1'b1;
            beats_left_q <= beats_left_q - 1'b1;
            gap_cnt_q    <= GAP_LOAD;
          end
        end
        ST_GAP:  gap_cnt_q <= gap_cnt_q - 4'd1;
        default: ;
      endcase
    end
  end

  ysyx_23060025_burst_mem_array #(
    .DEPTH_W (MEM_DEPTH_W),
    .DATA_W  (DATA_WIDTH)
  ) u_array (
    .clock   (clock),
    .reset   (reset),
    .rd_en   (rd_en),
    .rd_addr (word_idx_q),
    .rd_data (out_rdata),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

endmodule

// File: tb/tb_ysyx_23060025_burst_mem.sv
// Directed bench for ysyx_23060025_burst_mem. Two instances share the clock:
// dut_a uses FIRST_LAT=2, BEAT_GAP=0 and dut_b uses FIRST_LAT=1, BEAT_GAP=1.
// Each burst pushes its expected beats (data, last flag, cycle) into a
// scoreboard; a negedge monitor pops and compares every observed beat.
module tb_ysyx_23060025_burst_mem;

  localparam int DEPTH = 1024;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [31:0] a_paddr, b_paddr;
  logic        a_psel, b_psel;
  logic [7:0]  a_arlen, b_arlen;
  logic [2:0]  a_arsize, b_arsize;
  logic        a_rvalid, a_rlast, a_err, b_rvalid, b_rlast, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic [2:0]  a_dbg, b_dbg;
  logic        a_wr_en, b_wr_en;
  logic [9:0]  a_wr_addr, b_wr_addr;
  logic [31:0] a_wr_data, b_wr_data;

  ysyx_23060025_burst_mem #(.FIRST_LAT(2), .BEAT_GAP(0)) dut_a (
    .clock(clock), .reset(reset),
    .in_paddr(a_paddr), .in_psel(a_psel), .in_arlen(a_arlen), .in_arsize(a_arsize),
    .out_rvalid(a_rvalid), .out_rlast(a_rlast), .out_rdata(a_rdata), .out_err(a_err),
    .dbg_state(a_dbg),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data)
  );

  ysyx_23060025_burst_mem #(.FIRST_LAT(1), .BEAT_GAP(1)) dut_b (
    .clock(clock), .reset(reset),
    .in_paddr(b_paddr), .in_psel(b_psel), .in_arlen(b_arlen), .in_arsize(b_arsize),
    .out_rvalid(b_rvalid), .out_rlast(b_rlast), .out_rdata(b_rdata), .out_err(b_err),
    .dbg_state(b_dbg),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] a_exp_q[$], b_exp_q[$];
  logic        a_last_q[$], b_last_q[$];
  int          a_cyc_q[$], b_cyc_q[$];
  logic [31:0] mdl_a [DEPTH];
  logic [31:0] mdl_b [DEPTH];
  logic        a_exp_err, b_exp_err;

  int n_asserts = 0;
  int n_fail    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Monitors: every visible beat must match the head of its scoreboard.
  always @(negedge clock) begin
    chk("a_rlast_qualified", 32'(a_rlast & ~a_rvalid), 32'd0);
    if (a_rvalid) begin
      chk("a_beat_expected", 32'(a_exp_q.size() != 0), 32'd1);
      if (a_exp_q.size() != 0) begin
        chk("a_rdata", a_rdata, a_exp_q.pop_front());
        chk("a_rlast", 32'(a_rlast), 32'(a_last_q.pop_front()));
        chk("a_beat_cycle", 32'(cyc), 32'(a_cyc_q.pop_front()));
      end
    end
  end

  always @(negedge clock) begin
    chk("b_rlast_qualified", 32'(b_rlast & ~b_rvalid), 32'd0);
    if (b_rvalid) begin
      chk("b_beat_expected", 32'(b_exp_q.size() != 0), 32'd1);
      if (b_exp_q.size() != 0) begin
        chk("b_rdata", b_rdata, b_exp_q.pop_front());
        chk("b_rlast", 32'(b_rlast), 32'(b_last_q.pop_front()));
        chk("b_beat_cycle", 32'(cyc), 32'(b_cyc_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic preload(input bit sel_b, input int idx, input logic [31:0] d);
    if (!sel_b) begin
      a_wr_en = 1'b1; a_wr_addr = idx[9:0]; a_wr_data = d; mdl_a[idx] = d;
    end else begin
      b_wr_en = 1'b1; b_wr_addr = idx[9:0]; b_wr_data = d; mdl_b[idx] = d;
    end
    @(posedge clock); #1;
    a_wr_en = 1'b0;
    b_wr_en = 1'b0;
  endtask

  // Called 1 time unit after an edge; the request is accepted at the next edge k.
  task automatic start_burst(input bit sel_b, input logic [31:0] paddr,
                             input logic [7:0] arlen, input logic [2:0] arsize,
                             output int k);
    int fl, gap, idx, wi;
    bit bad;
    k   = cyc + 1;
    fl  = sel_b ? 1 : 2;
    gap = sel_b ? 1 : 0;
    idx = int'(paddr[11:2]);
    bad = (arsize != 3'b010) || (paddr[1:0] != 2'b00);
    for (int n = 0; n <= int'(arlen); n++) begin
      wi = (idx + n) % DEPTH;
      if (!sel_b) begin
        a_exp_q.push_back(mdl_a[wi]);
        a_last_q.push_back(n == int'(arlen));
        a_cyc_q.push_back(k + fl + n * (1 + gap));
      end else begin
        b_exp_q.push_back(mdl_b[wi]);
        b_last_q.push_back(n == int'(arlen));
        b_cyc_q.push_back(k + fl + n * (1 + gap));
      end
    end
    if (!sel_b) begin
      a_paddr = paddr; a_arlen = arlen; a_arsize = arsize; a_psel = 1'b1;
      if (bad) a_exp_err = 1'b1;
    end else begin
      b_paddr = paddr; b_arlen = arlen; b_arsize = arsize; b_psel = 1'b1;
      if (bad) b_exp_err = 1'b1;
    end
  endtask

  // Waits for rlast, keeps psel high for 'hold' more cycles, drops it, and
  // returns 1 time unit after the edge on which the responder is back in IDLE.
  task automatic finish_burst(input bit sel_b, input int k, input int hold);
    bit seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge clock);
      if (cyc == k + 1)
        chk(sel_b ? "b_err_after_accept" : "a_err_after_accept",
            32'(sel_b ? b_err : a_err), 32'(sel_b ? b_exp_err : a_exp_err));
      if (sel_b ? (b_rvalid && b_rlast) : (a_rvalid && a_rlast)) seen = 1'b1;
    end
    chk(sel_b ? "b_rlast_seen" : "a_rlast_seen", 32'(seen), 32'd1);
    repeat (hold) @(negedge clock);
    @(posedge clock); #1;
    if (!sel_b) a_psel = 1'b0; else b_psel = 1'b0;
    @(posedge clock); #1;
    chk(sel_b ? "b_state_idle" : "a_state_idle", 32'(sel_b ? b_dbg : a_dbg), 32'd0);
    chk(sel_b ? "b_queue_drained" : "a_queue_drained",
        32'(sel_b ? b_exp_q.size() : a_exp_q.size()), 32'd0);
  endtask

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    int guard;
    logic [31:0] pa;

    reset = 1'b1;
    a_paddr = '0; a_psel = 1'b0; a_arlen = '0; a_arsize = 3'b010;
    b_paddr = '0; b_psel = 1'b0; b_arlen = '0; b_arsize = 3'b010;
    a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0;
    b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
    a_exp_err = 1'b0; b_exp_err = 1'b0;

    // Reset values
    repeat (3) @(posedge clock);
    #1;
    chk("rst_rvalid", 32'(a_rvalid), 32'd0);
    chk("rst_rlast",  32'(a_rlast),  32'd0);
    chk("rst_rdata",  a_rdata,       32'd0);
    chk("rst_err",    32'(a_err),    32'd0);
    chk("rst_state",  32'(a_dbg),    32'd0);
    chk("rst_b_rvalid", 32'(b_rvalid), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Preload images
    preload(0, 4, 32'h0000_0013);
    preload(0, 5, 32'h0010_0093);
    preload(0, 6, $urandom);
    preload(0, 7, $urandom);
    preload(0, 1023, $urandom);
    preload(0, 0, $urandom);
    for (int i = 100; i < 132; i++) preload(0, i, $urandom);
    for (int i = 8; i < 12; i++) preload(1, i, $urandom);

    // Single-line refill
    start_burst(0, 32'h8000_0010, 8'd1, 3'b010, k);
    finish_burst(0, k, 0);
    chk("refill_err_clear", 32'(a_err), 32'd0);

    // Index wrap: mem[1023] then mem[0]
    start_burst(0, 32'h0000_0FFC, 8'd1, 3'b010, k);
    finish_burst(0, k, 0);

    // Single-beat burst
    start_burst(0, 32'h1234_5018, 8'd0, 3'b010, k);
    finish_burst(0, k, 0);

    // Error flag: bad size and misaligned address, beats still returned
    start_burst(0, 32'h8000_0012, 8'd1, 3'b011, k);
    finish_burst(0, k, 0);
    chk("err_sticky", 32'(a_err), 32'd1);

    // psel held 3 cycles past rlast, then an immediate new request
    start_burst(0, 32'h8000_0018, 8'd1, 3'b010, k);
    finish_burst(0, k, 3);
    start_burst(0, 32'h8000_0010, 8'd3, 3'b010, k);
    finish_burst(0, k, 0);
    chk("err_stays_after_legal", 32'(a_err), 32'd1);

    // Beat gap on the second instance
    start_burst(1, 32'h0000_0020, 8'd3, 3'b010, k);
    finish_burst(1, k, 0);

    // Random bursts inside the preloaded window with aliased upper bits
    for (int r = 0; r < 6; r++) begin
      pa = ($urandom & 32'hFFFF_F000) | (32'(100 + $urandom_range(0, 20)) << 2);
      start_burst(0, pa, 8'($urandom_range(0, 10)), 3'b010, k);
      finish_burst(0, k, $urandom_range(0, 2));
    end

    // Reset mid-burst: reset during beat 1 of a 4-beat burst
    start_burst(0, 32'h8000_0010, 8'd3, 3'b010, k);
    guard = 0;
    while (cyc != k + 3 && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    chk("reset_point_reached", 32'(cyc), 32'(k + 3));
    #2 reset = 1'b1;
    #1;
    chk("midrst_rvalid", 32'(a_rvalid), 32'd0);
    chk("midrst_rlast",  32'(a_rlast),  32'd0);
    chk("midrst_rdata",  a_rdata,       32'd0);
    chk("midrst_err",    32'(a_err),    32'd0);
    chk("midrst_state",  32'(a_dbg),    32'd0);
    a_exp_q.delete(); a_last_q.delete(); a_cyc_q.delete();
    a_exp_err = 1'b0; b_exp_err = 1'b0;
    a_psel = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (6) @(negedge clock);
    @(posedge clock); #1;

    // Memory survives reset
    start_burst(0, 32'h8000_0010, 8'd3, 3'b010, k);
    finish_burst(0, k, 0);

    chk("final_a_queue", 32'(a_exp_q.size()), 32'd0);
    chk("final_b_queue", 32'(b_exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
